// File: rtl/param_wb_cache_pkg.sv
`default_nettype none
// ============================================================================
// param_wb_cache_pkg : shared state encoding and address-split helpers
// Revision 1.0
// ============================================================================
package param_wb_cache_pkg;

    localparam int BYTE_OFF_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COMPARE   = 2'd1,
        ST_WRITEBACK = 2'd2,
        ST_ALLOCATE  = 2'd3
    } state_t;

    function automatic int tag_width(input int addr_w, input int index_w, input int offset_w);
        return addr_w - index_w - offset_w - BYTE_OFF_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_line_array.sv
`default_nettype none
// ============================================================================
// cache_line_array : V/D flops, tag and data storage with word-update and
//                    line-fill write ports, combinational read by index
// Revision 1.0
// ============================================================================
module cache_line_array
    import param_wb_cache_pkg::*;
#(
    parameter int INDEX_W  = 4,
    parameter int OFFSET_W = 2,
    parameter int TAG_W    = 26,
    parameter int DATA_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [INDEX_W-1:0]  i_index,
    input  logic [OFFSET_W-1:0] i_rd_off_a,
    input  logic [OFFSET_W-1:0] i_rd_off_b,
    output logic                o_valid,
    output logic                o_dirty,
    output logic [TAG_W-1:0]    o_tag,
    output logic [DATA_W-1:0]   o_rdata_a,
    output logic [DATA_W-1:0]   o_rdata_b,
    input  logic                i_wr_en,
    input  logic [OFFSET_W-1:0] i_wr_off,
    input  logic [DATA_W-1:0]   i_wr_data,
    input  logic                i_fill_en,
    input  logic                i_fill_last,
    input  logic [OFFSET_W-1:0] i_fill_off,
    input  logic [DATA_W-1:0]   i_fill_data,
    input  logic [TAG_W-1:0]    i_fill_tag
);

    localparam int c_SETS  = 1 << INDEX_W;
    localparam int c_WORDS = 1 << OFFSET_W;

    logic [c_SETS-1:0] r_valid;
    logic [c_SETS-1:0] r_dirty;
    logic [TAG_W-1:0]  r_tag  [c_SETS];
    logic [DATA_W-1:0] r_data [c_SETS*c_WORDS];

    // Any fill beat invalidates the line until its last beat lands, so an
    // abandoned refill never leaves a half-written line marked valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_fill_en) begin
            r_valid[i_index] <= i_fill_last;
            r_dirty[i_index] <= 1'b0;
        end else if (i_wr_en) begin
            r_dirty[i_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_fill_en) begin
            r_data[{i_index, i_fill_off}] <= i_fill_data;
            if (i_fill_last) begin
                r_tag[i_index] <= i_fill_tag;
            end
        end else if (i_wr_en) begin
            r_data[{i_index, i_wr_off}] <= i_wr_data;
        end
    end

    assign o_valid   = r_valid[i_index];
    assign o_dirty   = r_dirty[i_index];
    assign o_tag     = r_tag[i_index];
    assign o_rdata_a = r_data[{i_index, i_rd_off_a}];
    assign o_rdata_b = r_data[{i_index, i_rd_off_b}];

endmodule
`default_nettype wire

// File: rtl/param_wb_cache.sv
`default_nettype none
// ============================================================================
// param_wb_cache : direct-mapped write-back/write-allocate cache, burst memory
//                  port. Define CACHE_PERF_CNT_EN for hit/miss counters.
// Revision 1.0
// ============================================================================
module param_wb_cache
    import param_wb_cache_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int INDEX_W  = 4,
    parameter int OFFSET_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req_valid,
    input  logic              cpu_req_wr,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    input  logic [DATA_W-1:0] cpu_req_wdata,
    output logic              cpu_req_ready,
    output logic              cpu_resp_valid,
    output logic [DATA_W-1:0] cpu_resp_rdata,
`ifdef CACHE_PERF_CNT_EN
    output logic [31:0]       perf_hit_cnt,
    output logic [31:0]       perf_miss_cnt,
`endif
    output logic              mem_req_valid,
    output logic              mem_req_wr,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_req_ready,
    input  logic [DATA_W-1:0] mem_resp_rdata
);

    localparam int                c_TAG_W     = tag_width(ADDR_W, INDEX_W, OFFSET_W);
    localparam logic [OFFSET_W-1:0] c_LAST_BEAT = '1;

    state_t              r_state, w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_wr;
    logic [DATA_W-1:0]   r_wdata;
    logic [OFFSET_W-1:0] r_beat;

    logic [c_TAG_W-1:0]  w_req_tag, w_tag;
    logic [INDEX_W-1:0]  w_index;
    logic [OFFSET_W-1:0] w_req_off;
    logic                w_valid, w_dirty, w_hit;
    logic [DATA_W-1:0]   w_word, w_wb_word;
    logic                w_in_burst, w_beat_acc, w_last_acc;
    logic                w_wr_en, w_fill_en, w_fill_last;
    logic                w_unused_ok;

    assign w_req_tag   = r_addr[ADDR_W-1 -: c_TAG_W];
    assign w_index     = r_addr[BYTE_OFF_W+OFFSET_W +: INDEX_W];
    assign w_req_off   = r_addr[BYTE_OFF_W +: OFFSET_W];
    assign w_unused_ok = ^r_addr[BYTE_OFF_W-1:0];

    assign w_hit      = w_valid && (w_tag == w_req_tag);
    assign w_in_burst = (r_state == ST_WRITEBACK) || (r_state == ST_ALLOCATE);
    assign w_beat_acc = w_in_burst && mem_req_ready;
    assign w_last_acc = w_beat_acc && (r_beat == c_LAST_BEAT);

    cache_line_array #(
        .INDEX_W  (INDEX_W),
        .OFFSET_W (OFFSET_W),
        .TAG_W    (c_TAG_W),
        .DATA_W   (DATA_W)
    ) u_lines (
        .clk         (clk),
        .rst         (rst),
        .i_index     (w_index),
        .i_rd_off_a  (w_req_off),
        .i_rd_off_b  (r_beat),
        .o_valid     (w_valid),
        .o_dirty     (w_dirty),
        .o_tag       (w_tag),
        .o_rdata_a   (w_word),
        .o_rdata_b   (w_wb_word),
        .i_wr_en     (w_wr_en),
        .i_wr_off    (w_req_off),
        .i_wr_data   (r_wdata),
        .i_fill_en   (w_fill_en),
        .i_fill_last (w_fill_last),
        .i_fill_off  (r_beat),
        .i_fill_data (mem_resp_rdata),
        .i_fill_tag  (w_req_tag)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_beat  <= '0;
            r_addr  <= '0;
            r_wr    <= 1'b0;
            r_wdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_beat_acc) begin
                r_beat <= r_beat + 1'b1;
            end
            if (r_state == ST_IDLE && cpu_req_valid) begin
                r_addr  <= cpu_req_addr;
                r_wr    <= cpu_req_wr;
                r_wdata <= cpu_req_wdata;
            end
        end
    end

    always_comb begin
        w_next         = r_state;
        cpu_req_ready  = 1'b0;
        cpu_resp_valid = 1'b0;
        cpu_resp_rdata = '0;
        mem_req_valid  = 1'b0;
        mem_req_wr     = 1'b0;
        mem_req_addr   = '0;
        mem_req_wdata  = '0;
        w_wr_en        = 1'b0;
        w_fill_en      = 1'b0;
        w_fill_last    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cpu_req_ready = !rst;
                if (cpu_req_valid) begin
                    w_next = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if (w_hit) begin
                    cpu_resp_valid = 1'b1;
                    cpu_resp_rdata = w_word;
                    w_wr_en        = r_wr;
                    w_next         = ST_IDLE;
                end else if (w_dirty) begin
                    w_next = ST_WRITEBACK;
                end else begin
                    w_next = ST_ALLOCATE;
                end
            end
            ST_WRITEBACK: begin
                mem_req_valid = 1'b1;
                mem_req_wr    = 1'b1;
                mem_req_addr  = {w_tag, w_index, r_beat, 2'b00};
                mem_req_wdata = w_wb_word;
                if (w_last_acc) begin
                    w_next = ST_ALLOCATE;
                end
            end
            ST_ALLOCATE: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {w_req_tag, w_index, r_beat, 2'b00};
                w_fill_en     = w_beat_acc;
                w_fill_last   = w_last_acc;
                if (w_last_acc) begin
                    w_next = ST_COMPARE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

`ifdef CACHE_PERF_CNT_EN
    logic        r_refilled;
    logic [31:0] r_hit_cnt, r_miss_cnt;

    // The compare that follows a refill always hits and is not a new request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_refilled <= 1'b0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (r_state == ST_IDLE && cpu_req_valid) begin
                r_refilled <= 1'b0;
            end else if (r_state == ST_ALLOCATE && w_last_acc) begin
                r_refilled <= 1'b1;
            end
            if (r_state == ST_COMPARE && !r_refilled) begin
                if (w_hit) begin
                    r_hit_cnt <= r_hit_cnt + 32'd1;
                end else begin
                    r_miss_cnt <= r_miss_cnt + 32'd1;
                end
            end
        end
    end

    assign perf_hit_cnt  = r_hit_cnt;
    assign perf_miss_cnt = r_miss_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_param_wb_cache.sv
`default_nettype none
// ============================================================================
// tb_param_wb_cache : directed vector bench; memory model returns data = addr
// Revision 1.0
// ============================================================================
module tb_param_wb_cache;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req_valid = 1'b0;
    logic        cpu_req_wr = 1'b0;
    logic [31:0] cpu_req_addr = '0;
    logic [31:0] cpu_req_wdata = '0;
    logic        cpu_req_ready;
    logic        cpu_resp_valid;
    logic [31:0] cpu_resp_rdata;
    logic        mem_req_valid;
    logic        mem_req_wr;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_resp_rdata;

    always #5 clk = ~clk;

    param_wb_cache dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_req_valid  (cpu_req_valid),
        .cpu_req_wr     (cpu_req_wr),
        .cpu_req_addr   (cpu_req_addr),
        .cpu_req_wdata  (cpu_req_wdata),
        .cpu_req_ready  (cpu_req_ready),
        .cpu_resp_valid (cpu_resp_valid),
        .cpu_resp_rdata (cpu_resp_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_wr     (mem_req_wr),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_rdata (mem_resp_rdata)
    );

    assign mem_resp_rdata = mem_req_addr;

    int          n_pass = 0;
    int          n_total = 0;
    int          resp_pulses = 0;
    int          stall_cfg = 0;
    int          stall_cnt = 0;
    bit          stalling = 1'b0;
    logic [31:0] snap_addr, snap_wdata;
    logic        snap_wr;
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    logic        log_wr[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Memory side: decides ready for the coming edge, logs accepted beats and
    // checks that a stalled beat is held unchanged.
    always @(negedge clk) begin
        if (cpu_resp_valid) resp_pulses++;
        if (mem_req_valid) begin
            if (stalling) begin
                chk("hold_addr", mem_req_addr, snap_addr);
                chk("hold_wdata", mem_req_wdata, snap_wdata);
                chk("hold_wr", {31'd0, mem_req_wr}, {31'd0, snap_wr});
            end
            if (stall_cnt < stall_cfg) begin
                if (!stalling) begin
                    snap_addr  = mem_req_addr;
                    snap_wdata = mem_req_wdata;
                    snap_wr    = mem_req_wr;
                end
                stalling      = 1'b1;
                stall_cnt++;
                mem_req_ready = 1'b0;
            end else begin
                mem_req_ready = 1'b1;
                stall_cnt     = 0;
                stalling      = 1'b0;
                log_addr.push_back(mem_req_addr);
                log_data.push_back(mem_req_wdata);
                log_wr.push_back(mem_req_wr);
            end
        end else begin
            if (stalling) chk("hold_valid", 32'd0, 32'd1);
            mem_req_ready = 1'b0;
            stall_cnt     = 0;
            stalling      = 1'b0;
        end
    end

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        log_wr.delete();
    endtask

    task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input bit hold, output logic [31:0] rdata, output int lat);
        bit acc = 1'b0;
        bit got = 1'b0;
        int p0;
        rdata = '0;
        lat   = 0;
        @(posedge clk); #1;
        clear_log();
        cpu_req_valid = 1'b1;
        cpu_req_wr    = wr;
        cpu_req_addr  = addr;
        cpu_req_wdata = wdata;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cpu_req_ready) begin
                acc = 1'b1;
                break;
            end
        end
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
        p0 = resp_pulses;
        @(posedge clk); #1;
        if (!hold) cpu_req_valid = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            lat++;
            if (cpu_resp_valid) begin
                got   = 1'b1;
                rdata = cpu_resp_rdata;
                break;
            end
            if (hold) chk("ready_low_busy", {31'd0, cpu_req_ready}, 32'd0);
        end
        if (!got) chk("resp_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        cpu_req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("one_resp_pulse", resp_pulses - p0, 32'd1);
    endtask

    task automatic check_beats(input string tag, input int n_wr, input int n_rd,
                               input logic [31:0] wb_base, input logic [31:0] rd_base,
                               input logic [31:0] sp_addr, input logic [31:0] sp_data);
        logic [31:0] ea, ed;
        chk({tag, "_nbeats"}, log_addr.size(), n_wr + n_rd);
        if (log_addr.size() == n_wr + n_rd) begin
            for (int k = 0; k < n_wr + n_rd; k++) begin
                if (k < n_wr) begin
                    ea = wb_base + 32'(4 * k);
                    ed = (ea == sp_addr) ? sp_data : ea;
                    chk($sformatf("%s_wb%0d_wr", tag, k), {31'd0, log_wr[k]}, 32'd1);
                    chk($sformatf("%s_wb%0d_addr", tag, k), log_addr[k], ea);
                    chk($sformatf("%s_wb%0d_data", tag, k), log_data[k], ed);
                end else begin
                    ea = rd_base + 32'(4 * (k - n_wr));
                    chk($sformatf("%s_rd%0d_wr", tag, k), {31'd0, log_wr[k]}, 32'd0);
                    chk($sformatf("%s_rd%0d_addr", tag, k), log_addr[k], ea);
                end
            end
        end
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          n_wr;
        int          n_rd;
        logic [31:0] wb_base;
        logic [31:0] rd_base;
        logic [31:0] sp_addr;
        logic [31:0] sp_data;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [31:0] rd;
        int          lat;
        bit          seen;

        vecs[0] = '{1'b0, 32'h1234, 32'h0,        32'h1234,     6, 0, 4, 32'h0,    32'h1230, 32'hFFFF_FFFF, 32'h0};
        vecs[1] = '{1'b0, 32'h1238, 32'h0,        32'h1238,     1, 0, 0, 32'h0,    32'h0,    32'hFFFF_FFFF, 32'h0};
        vecs[2] = '{1'b1, 32'h1234, 32'hDEADBEEF, 32'h0,        1, 0, 0, 32'h0,    32'h0,    32'hFFFF_FFFF, 32'h0};
        vecs[3] = '{1'b0, 32'h1234, 32'h0,        32'hDEADBEEF, 1, 0, 0, 32'h0,    32'h0,    32'hFFFF_FFFF, 32'h0};
        vecs[4] = '{1'b0, 32'h2234, 32'h0,        32'h2234,    10, 4, 4, 32'h1230, 32'h2230, 32'h1234, 32'hDEADBEEF};
        vecs[5] = '{1'b1, 32'h3238, 32'h12345678, 32'h0,        6, 0, 4, 32'h0,    32'h3230, 32'hFFFF_FFFF, 32'h0};
        vecs[6] = '{1'b0, 32'h3238, 32'h0,        32'h12345678, 1, 0, 0, 32'h0,    32'h0,    32'hFFFF_FFFF, 32'h0};
        vecs[7] = '{1'b0, 32'h0040, 32'h0,        32'h0040,     6, 0, 4, 32'h0,    32'h0040, 32'hFFFF_FFFF, 32'h0};
        vecs[8] = '{1'b0, 32'h2230, 32'h0,        32'h2230,    10, 4, 4, 32'h3230, 32'h2230, 32'h3238, 32'h12345678};
        vecs[9] = '{1'b0, 32'h004C, 32'h0,        32'h004C,     1, 0, 0, 32'h0,    32'h0,    32'hFFFF_FFFF, 32'h0};

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready_low", {31'd0, cpu_req_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, cpu_req_ready}, 32'd1);
        chk("post_rst_resp_valid", {31'd0, cpu_resp_valid}, 32'd0);
        chk("post_rst_resp_rdata", cpu_resp_rdata, 32'd0);
        chk("post_rst_mem_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("post_rst_mem_wr", {31'd0, mem_req_wr}, 32'd0);
        chk("post_rst_mem_addr", mem_req_addr, 32'd0);
        chk("post_rst_mem_wdata", mem_req_wdata, 32'd0);

        for (int i = 0; i < 10; i++) begin
            do_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0, rd, lat);
            if (!vecs[i].wr) chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            check_beats($sformatf("v%0d", i), vecs[i].n_wr, vecs[i].n_rd,
                        vecs[i].wb_base, vecs[i].rd_base, vecs[i].sp_addr, vecs[i].sp_data);
        end

        // Refill with 5 stall cycles per beat
        stall_cfg = 5;
        do_req(1'b0, 32'h5670, 32'h0, 1'b0, rd, lat);
        stall_cfg = 0;
        chk("stall_rdata", rd, 32'h5670);
        chk("stall_latency", lat, 32'd26);
        check_beats("stall", 0, 4, 32'h0, 32'h5670, 32'hFFFF_FFFF, 32'h0);

        // Reset in the middle of a refill
        @(posedge clk); #1;
        clear_log();
        cpu_req_valid = 1'b1;
        cpu_req_wr    = 1'b0;
        cpu_req_addr  = 32'h1234;
        @(negedge clk);
        chk("abort_accept", {31'd0, cpu_req_ready}, 32'd1);
        @(posedge clk); #1;
        cpu_req_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (log_addr.size() >= 2) begin
                seen = 1'b1;
                break;
            end
        end
        chk("abort_two_beats", {31'd0, seen}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_rst_ready_low", {31'd0, cpu_req_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_mem_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("abort_ready", {31'd0, cpu_req_ready}, 32'd1);
        chk("abort_resp_valid", {31'd0, cpu_resp_valid}, 32'd0);
        do_req(1'b0, 32'h1234, 32'h0, 1'b0, rd, lat);
        chk("after_abort_rdata", rd, 32'h1234);
        chk("after_abort_latency", lat, 32'd6);
        check_beats("after_abort", 0, 4, 32'h0, 32'h1230, 32'hFFFF_FFFF, 32'h0);

        // Request valid held high across a clean miss
        do_req(1'b0, 32'h6634, 32'h0, 1'b1, rd, lat);
        chk("hold_req_rdata", rd, 32'h6634);
        chk("hold_req_latency", lat, 32'd6);
        check_beats("hold_req", 0, 4, 32'h0, 32'h6630, 32'hFFFF_FFFF, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/param_wb_cache.md
Name: param_wb_cache

Overview:
Parametrised direct-mapped, write-back, write-allocate cache for the instruction/data path.
- Sits between the CPU pipeline and a single-word-per-beat memory port.
- Successor to the single-word fixed-geometry cache: configurable set count and block size, CPU reads and writes, multi-beat block writeback and refill.

Parameters:
ADDR_W, 32, byte-address width
DATA_W, 32, word width; must be 32 (2 byte-offset bits)
INDEX_W, 4, log2 of the number of sets
OFFSET_W, 2, log2 of words per block (beats per burst)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
cpu_req_valid  in  1  CPU request present
cpu_req_wr  in  1  1 = write, 0 = read
cpu_req_addr  in  ADDR_W  byte address; word-aligned
cpu_req_wdata  in  DATA_W  write data
cpu_req_ready  out  1  cache accepts a request this cycle
cpu_resp_valid  out  1  one-cycle pulse: request complete
cpu_resp_rdata  out  DATA_W  read data, valid with cpu_resp_valid
mem_req_valid  out  1  memory beat request
mem_req_wr  out  1  1 = write beat
mem_req_addr  out  ADDR_W  word address of the current beat
mem_req_wdata  out  DATA_W  write-beat data
mem_req_ready  in  1  beat accepted this cycle; read data valid this cycle
mem_resp_rdata  in  DATA_W  read-beat data

Behaviour:
- Address split, LSB to MSB: byte offset [1:0]; word offset [OFFSET_W+1:2]; index (next INDEX_W bits); tag (remaining bits).
- Line storage: V and D bits in flops; tag; 2^OFFSET_W data words.
- FSM states are IDLE, COMPARE, WRITEBACK and ALLOCATE.
- IDLE:
  - cpu_req_ready=1.
  - On cpu_req_valid, latch addr, wr and wdata, then go to COMPARE.
- COMPARE:
  - Hit means V=1 and the stored tag equals the request tag.
  - Hit read: cpu_resp_valid=1 with the word; go to IDLE.
  - Hit write: update the word, set D=1, pulse cpu_resp_valid; go to IDLE.
  - Miss with D=1: go to WRITEBACK.
  - Miss with D=0: go to ALLOCATE.
- WRITEBACK:
  - Issue 2^OFFSET_W write beats, word offset 0 upward.
  - Beat address is {stored tag, index, beat count, 2'b00}.
  - The beat count advances only on mem_req_valid && mem_req_ready.
  - After the last beat is accepted, go to ALLOCATE.
- ALLOCATE:
  - Issue read beats at {request tag, index, beat count, 2'b00}.
  - Capture mem_resp_rdata into the line on each accepted beat.
  - After the last beat: V=1, tag=request tag, D=0; go to COMPARE, which then hits.
- mem_req_valid, addr, wr and wdata stay stable while mem_req_ready=0; a stall of any length is legal.
- cpu_req_ready=0 in every state except IDLE; cpu_req_valid is ignored there, so exactly one request is outstanding.
- Latency:
  - Hit: cpu_resp_valid in the cycle after acceptance.
  - Clean miss: 1 + N accepted beats + 1 cycles, at minimum.
  - Dirty miss: adds N writeback beats.
- Writes are full-word only; write-allocate on a write miss.
- Reset values:
  - FSM state: IDLE.
  - Outputs: cpu_req_ready=0 during rst, 1 from the first cycle after it; cpu_resp_valid=0; mem_req_valid=0; mem_req_wr=0; mem_req_addr=0; mem_req_wdata=0; cpu_resp_rdata=0.
  - All V and D bits clear; tag and data arrays are not reset.
- rst during a burst: abandon the burst; mem_req_valid=0 in the next cycle; the partially filled line stays invalid.

Optional Feature:
Macro CACHE_PERF_CNT_EN.
- Defined: adds output ports perf_hit_cnt[31:0] and perf_miss_cnt[31:0].
  - Each counts COMPARE-state evaluations of an original request; the post-refill re-compare is not counted.
  - Counters wrap at 2^32 and reset to 0.
- Undefined: the ports and counters are absent; functional behaviour is identical.

Decomposition:
- Shared header/package cache_pkg.vh holds:
  - state encodings (IDLE, COMPARE, WRITEBACK, ALLOCATE);
  - line-field position macros (V, D, tag MSB/LSB);
  - address-split width helpers.
- One sub-module, cache_line_array: V/D flops, tag and data storage, synchronous write ports for word update and line fill, combinational read by index.
- The FSM and beat counter stay in param_wb_cache.

Test Plan:
All scenarios use default parameters, and memory returns data = address.
1. Reset, then read 0x00001234 -> 4 read beats at 0x1230, 0x1234, 0x1238, 0x123C; cpu_resp_rdata=0x00001234.
2. Then read 0x00001238 -> hit; cpu_resp_valid in the cycle after acceptance, data 0x1238; mem_req_valid stays 0.
3. Write 0x1234 = 0xDEADBEEF (hit), then read 0x2234:
   - writeback beats 0x1230..0x123C with 0x1234 carrying 0xDEADBEEF;
   - then read beats 0x2230..0x223C;
   - cpu_resp_rdata=0x2234.
4. mem_req_ready low 5 cycles per beat during a refill -> mem_req_valid, mem_req_addr and mem_req_wdata held constant; the beat count advances only on ready.
5. rst pulsed after 2 accepted refill beats -> mem_req_valid=0 next cycle; a subsequent read of 0x1234 misses and refills all 4 beats.
6. cpu_req_valid held high across a miss -> cpu_req_ready=0 until IDLE; exactly one cpu_resp_valid pulse per accepted request.
